// File: rtl/cordic_pipe.sv
// Fully pipelined CORDIC engine: quadrant pre-rotation, ITER micro-rotation stages,
// optional 1/K gain compensation and saturation, under a global valid/ready stall.

module cordic_stage #(
  parameter int XW  = 18,
  parameter int AW  = 16,
  parameter int IDX = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 mode,
  input  logic signed [XW-1:0] x,
  input  logic signed [XW-1:0] y,
  input  logic signed [AW-1:0] z,
  output logic                 mode_q,
  output logic signed [XW-1:0] x_q,
  output logic signed [XW-1:0] y_q,
  output logic signed [AW-1:0] z_q
);
  // atan(2^-i) in hundredths of a degree, rounded
  function automatic int atan_cdeg(input int i);
    case (i)
      0:  return 4500;
      1:  return 2657;
      2:  return 1404;
      3:  return 713;
      4:  return 358;
      5:  return 179;
      6:  return 90;
      7:  return 45;
      8:  return 22;
      9:  return 11;
      10: return 6;
      11: return 3;
      12: return 1;
      13: return 1;
      default: return 0;
    endcase
  endfunction

  localparam logic signed [AW-1:0] ANG = AW'(atan_cdeg(IDX));

  logic                 d_pos;
  logic signed [XW-1:0] xs, ys;

  assign d_pos = mode ? y[XW-1] : !z[AW-1];
  assign xs    = x >>> IDX;
  assign ys    = y >>> IDX;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q <= 1'b0;
      x_q    <= '0;
      y_q    <= '0;
      z_q    <= '0;
    end else if (en) begin
      mode_q <= mode;
      x_q    <= d_pos ? x - ys : x + ys;
      y_q    <= d_pos ? y + xs : y - xs;
      z_q    <= d_pos ? z - ANG : z + ANG;
    end
  end
endmodule

module cordic_pipe #(
  parameter int W         = 16,
  parameter int AW        = 16,
  parameter int ITER      = 12,
  parameter int GAIN_COMP = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_mode,
  input  logic [W-1:0]  in_x,
  input  logic [W-1:0]  in_y,
  input  logic [AW-1:0] in_z,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_mode,
  output logic [W-1:0]  out_x,
  output logic [W-1:0]  out_y,
  output logic [AW-1:0] out_z
);
  localparam int XW = W + 2;
  localparam logic signed [AW-1:0] Z90  = AW'(9000);
  localparam logic signed [AW-1:0] Z180 = AW'(18000);
  localparam logic signed [XW-1:0] VMAX = XW'((1 << (W-1)) - 1);
  localparam logic signed [XW-1:0] VMIN = XW'(-(1 << (W-1)));

  logic adv;
  // [0] = pre-rotation, [1..ITER] = micro-rotations, [ITER+1] = output
  logic [ITER+1:0] vld_pipe;

  assign adv       = !out_valid || out_ready;
  assign in_ready  = adv;
  assign out_valid = vld_pipe[ITER+1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) vld_pipe <= '0;
    else if (adv) vld_pipe <= {vld_pipe[ITER:0], in_valid};
  end

  logic signed [XW-1:0] ext_x, ext_y, px_n, py_n, p_x, p_y;
  logic signed [AW-1:0] zi, pz_n, p_z;
  logic                 p_mode;

  assign ext_x = {{2{in_x[W-1]}}, in_x};
  assign ext_y = {{2{in_y[W-1]}}, in_y};
  assign zi    = in_z;

  always_comb begin
    px_n = ext_x;
    py_n = ext_y;
    pz_n = zi;
    if (!in_mode) begin
      if (zi > Z90) begin
        px_n = -ext_x;
        py_n = -ext_y;
        pz_n = zi - Z180;
      end else if (zi < -Z90) begin
        px_n = -ext_x;
        py_n = -ext_y;
        pz_n = zi + Z180;
      end
    end else begin
      pz_n = '0;
      // left half-plane: fold into right half, remember +/-180 by original y sign
      if (ext_x[XW-1]) begin
        px_n = -ext_x;
        py_n = -ext_y;
        pz_n = in_y[W-1] ? -Z180 : Z180;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_mode <= 1'b0;
      p_x    <= '0;
      p_y    <= '0;
      p_z    <= '0;
    end else if (adv) begin
      p_mode <= in_mode;
      p_x    <= px_n;
      p_y    <= py_n;
      p_z    <= pz_n;
    end
  end

  logic [ITER-1:0]          s_mode;
  logic [ITER-1:0][XW-1:0]  s_x, s_y;
  logic [ITER-1:0][AW-1:0]  s_z;

  for (genvar i = 0; i < ITER; i++) begin : g_stage
    if (i == 0) begin : g_first
      cordic_stage #(.XW(XW), .AW(AW), .IDX(i)) u_stage (
        .clk(clk), .rst(rst), .en(adv),
        .mode(p_mode), .x(p_x), .y(p_y), .z(p_z),
        .mode_q(s_mode[i]), .x_q(s_x[i]), .y_q(s_y[i]), .z_q(s_z[i])
      );
    end else begin : g_rest
      cordic_stage #(.XW(XW), .AW(AW), .IDX(i)) u_stage (
        .clk(clk), .rst(rst), .en(adv),
        .mode(s_mode[i-1]), .x(s_x[i-1]), .y(s_y[i-1]), .z(s_z[i-1]),
        .mode_q(s_mode[i]), .x_q(s_x[i]), .y_q(s_y[i]), .z_q(s_z[i])
      );
    end
  end

  logic signed [XW-1:0] l_x, l_y, g_x, g_y;

  assign l_x = s_x[ITER-1];
  assign l_y = s_y[ITER-1];
  // 1/K ~= 0.607422 via shift-add
  assign g_x = (GAIN_COMP != 0) ? (l_x >>> 1) + (l_x >>> 3) - (l_x >>> 6) - (l_x >>> 9) : l_x;
  assign g_y = (GAIN_COMP != 0) ? (l_y >>> 1) + (l_y >>> 3) - (l_y >>> 6) - (l_y >>> 9) : l_y;

  function automatic logic [W-1:0] sat(input logic signed [XW-1:0] v);
    if (v > VMAX)      return VMAX[W-1:0];
    else if (v < VMIN) return VMIN[W-1:0];
    else               return v[W-1:0];
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_mode <= 1'b0;
      out_x    <= '0;
      out_y    <= '0;
      out_z    <= '0;
    end else if (adv) begin
      out_mode <= s_mode[ITER-1];
      out_x    <= sat(g_x);
      out_y    <= sat(g_y);
      out_z    <= s_z[ITER-1];
    end
  end
endmodule

// File: tb/tb_cordic_pipe.sv
// Bench for cordic_pipe: directed vector table, mixed-mode stream with a stall window,
// reset with samples in flight, and saturation on an uncompensated instance.

module tb_cordic_pipe;
  localparam int W = 16, AW = 16, ITER = 12;
  localparam real PI = 3.14159265358979;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic in_valid, in_ready, in_mode, out_valid, out_ready, out_mode;
  logic [W-1:0] in_x, in_y, out_x, out_y;
  logic [AW-1:0] in_z, out_z;

  logic r_in_valid, r_in_ready, r_in_mode, r_out_valid, r_out_mode;
  logic [W-1:0] r_in_x, r_in_y, r_out_x, r_out_y;
  logic [AW-1:0] r_in_z, r_out_z;

  cordic_pipe #(.W(W), .AW(AW), .ITER(ITER), .GAIN_COMP(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
    .in_x(in_x), .in_y(in_y), .in_z(in_z), .out_valid(out_valid), .out_ready(out_ready),
    .out_mode(out_mode), .out_x(out_x), .out_y(out_y), .out_z(out_z)
  );

  cordic_pipe #(.W(W), .AW(AW), .ITER(ITER), .GAIN_COMP(0)) dut_raw (
    .clk(clk), .rst(rst), .in_valid(r_in_valid), .in_ready(r_in_ready), .in_mode(r_in_mode),
    .in_x(r_in_x), .in_y(r_in_y), .in_z(r_in_z), .out_valid(r_out_valid), .out_ready(1'b1),
    .out_mode(r_out_mode), .out_x(r_out_x), .out_y(r_out_y), .out_z(r_out_z)
  );

  typedef struct {
    bit  mode;
    int  x, y, z;
    real ex, ey, ez;
  } vec_t;

  typedef struct {
    bit  mode;
    real ex, ey, ez, txy, tz;
    int  acc_cyc, acc_stall;
  } sb_t;

  sb_t sb[$];
  sb_t cur, mon_e;
  vec_t tbl[10];

  int checks = 0, failures = 0;
  int cyc = 0, stall_cnt = 0, pops = 0, pops0;
  int stall_from = -100;
  bit force_stall = 0;
  bit hold_prev = 0;
  int hx, hy, hz, hm;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk_eq(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  task automatic chk_tol(input string nm, input int act, input real exp, input real tol);
    checks++;
    if ((act - exp > tol) || (exp - act > tol)) begin
      failures++;
      $display("FAIL %s: got %0d, want %0.1f +/- %0.1f", nm, act, exp, tol);
    end
  endtask

  function automatic sb_t model(input bit m, input int x, input int y, input int z,
                                input real txy, input real tz);
    sb_t e;
    real rx, ry, a;
    rx = x;
    ry = y;
    e.mode = m; e.txy = txy; e.tz = tz; e.acc_cyc = 0; e.acc_stall = 0;
    if (!m) begin
      a = z * PI / 18000.0;
      e.ex = rx * $cos(a) - ry * $sin(a);
      e.ey = rx * $sin(a) + ry * $cos(a);
      e.ez = 0.0;
    end else begin
      e.ex = $sqrt(rx * rx + ry * ry);
      e.ey = 0.0;
      e.ez = $atan2(ry, rx) * 18000.0 / PI;
    end
    return e;
  endfunction

  // scoreboard side: push on acceptance, pop and compare on delivery
  always @(negedge clk) begin
    if (rst) begin
      hold_prev = 0;
    end else begin
      if (!in_ready) stall_cnt++;
      if (hold_prev) begin
        chk_eq("hold_x", $signed(out_x), hx);
        chk_eq("hold_y", $signed(out_y), hy);
        chk_eq("hold_z", $signed(out_z), hz);
        chk_eq("hold_mode", int'(out_mode), hm);
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_output: got x=%0d y=%0d z=%0d, want none",
                   $signed(out_x), $signed(out_y), $signed(out_z));
        end else begin
          mon_e = sb.pop_front();
          chk_eq("mode", int'(out_mode), int'(mon_e.mode));
          chk_tol("out_x", $signed(out_x), mon_e.ex, mon_e.txy);
          chk_tol("out_y", $signed(out_y), mon_e.ey, mon_e.txy);
          chk_tol("out_z", $signed(out_z), mon_e.ez, mon_e.tz);
          chk_eq("latency", cyc - mon_e.acc_cyc, ITER + 2 + stall_cnt - mon_e.acc_stall);
          pops++;
        end
      end
      if (in_valid && in_ready) begin
        mon_e = cur;
        mon_e.acc_cyc = cyc;
        mon_e.acc_stall = stall_cnt;
        sb.push_back(mon_e);
      end
      hold_prev = out_valid && !out_ready;
      hx = $signed(out_x); hy = $signed(out_y); hz = $signed(out_z); hm = int'(out_mode);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    out_ready = !force_stall && !(cyc >= stall_from && cyc < stall_from + 5);
  endtask

  task automatic send(input bit m, input int x, input int y, input int z);
    bit done;
    done = 0;
    in_mode = m; in_x = W'(x); in_y = W'(y); in_z = AW'(z); in_valid = 1'b1;
    for (int n = 0; n < 100 && !done; n++) begin
      #1;
      done = in_ready;
      tick();
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: got in_ready=0, want acceptance within 100 cycles");
    end
  endtask

  task automatic drain(input int lim);
    for (int n = 0; n < lim && sb.size() != 0; n++) tick();
    chk_eq("drain_left", sb.size(), 0);
  endtask

  initial begin
    int m, x, y, z;
    tbl[0] = '{0, 10000,      0,   3000,  8660.25,  5000.0,     0.0};
    tbl[1] = '{1, 10000,  10000,      0, 14142.14,     0.0,  4500.0};
    tbl[2] = '{1, -10000,     0,      0, 10000.0,      0.0, 18000.0};
    tbl[3] = '{0, 10000,      0, -13500, -7071.07, -7071.07,    0.0};
    tbl[4] = '{0,     0,  10000,      0,     0.0,  10000.0,     0.0};
    tbl[5] = '{1,     0,  -8000,      0,  8000.0,      0.0, -9000.0};
    tbl[6] = '{0, 10000,      0,  18000, -10000.0,     0.0,     0.0};
    tbl[7] = '{0, 10000,      0,   9000,     0.0,  10000.0,     0.0};
    tbl[8] = '{0, 10000,      0, -18000, -10000.0,     0.0,     0.0};
    tbl[9] = '{1, -5000,  -5000,      0,  7071.07,     0.0, -13500.0};

    in_valid = 0; in_mode = 0; in_x = '0; in_y = '0; in_z = '0; out_ready = 1;
    r_in_valid = 0; r_in_mode = 0; r_in_x = '0; r_in_y = '0; r_in_z = '0;

    repeat (3) @(posedge clk);
    #1;
    chk_eq("rst_out_valid", int'(out_valid), 0);
    chk_eq("rst_out_x", int'(out_x), 0);
    chk_eq("rst_out_y", int'(out_y), 0);
    chk_eq("rst_out_z", int'(out_z), 0);
    chk_eq("rst_out_mode", int'(out_mode), 0);
    chk_eq("rst_in_ready", int'(in_ready), 1);
    rst = 0;
    tick();

    // directed vectors, one at a time
    for (int i = 0; i < 10; i++) begin
      cur = '{tbl[i].mode, tbl[i].ex, tbl[i].ey, tbl[i].ez, 8.0, 3.0, 0, 0};
      send(tbl[i].mode, tbl[i].x, tbl[i].y, tbl[i].z);
      in_valid = 0;
      drain(60);
    end

    // mixed-mode stream with five stalled cycles once outputs are flowing
    pops0 = pops;
    stall_from = cyc + 18;
    for (int k = 0; k < 20; k++) begin
      m = int'($urandom_range(0, 1));
      x = int'($urandom_range(0, 16000)) - 8000;
      y = int'($urandom_range(0, 16000)) - 8000;
      z = int'($urandom_range(0, 36000)) - 18000;
      if (m == 1 && (x < 3000 && x > -3000) && (y < 3000 && y > -3000)) x = 6000;
      cur = model(m[0], x, y, z, 12.0, 6.0);
      send(m[0], x, y, z);
    end
    in_valid = 0;
    drain(200);
    chk_eq("stream_count", pops - pops0, 20);
    stall_from = -100;

    // reset with six samples in flight, head of the pipe stalled at the output
    force_stall = 1;
    out_ready = 0;
    for (int k = 0; k < 6; k++) begin
      cur = model(0, 4000 + 100 * k, 0, 1000, 8.0, 3.0);
      send(0, 4000 + 100 * k, 0, 1000);
    end
    in_valid = 0;
    for (int n = 0; n < 40 && !out_valid; n++) tick();
    chk_eq("pre_rst_valid", int'(out_valid), 1);
    rst = 1;
    #1;
    chk_eq("midrst_out_valid", int'(out_valid), 0);
    chk_eq("midrst_out_x", int'(out_x), 0);
    chk_eq("midrst_out_y", int'(out_y), 0);
    chk_eq("midrst_out_z", int'(out_z), 0);
    chk_eq("midrst_out_mode", int'(out_mode), 0);
    chk_eq("midrst_in_ready", int'(in_ready), 1);
    sb.delete();
    tick();
    tick();
    rst = 0;
    force_stall = 0;
    out_ready = 1;
    pops0 = pops;
    cur = model(1, 3000, 4000, 0, 8.0, 3.0);
    send(1, 3000, 4000, 0);
    in_valid = 0;
    drain(40);
    repeat (5) tick();
    chk_eq("post_rst_count", pops - pops0, 1);

    // saturation without gain compensation
    r_in_valid = 1; r_in_mode = 1; r_in_x = W'(32767); r_in_y = W'(32767); r_in_z = '0;
    #1;
    chk_eq("sat_in_ready", int'(r_in_ready), 1);
    tick();
    r_in_valid = 0;
    for (int n = 0; n < 40 && !r_out_valid; n++) tick();
    chk_eq("sat_valid", int'(r_out_valid), 1);
    chk_eq("sat_x", $signed(r_out_x), 32767);
    chk_eq("sat_mode", int'(r_out_mode), 1);
    chk_tol("sat_z", $signed(r_out_z), 4500.0, 3.0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
